reg_port_arbiter: RTL and testbench
===================================

# reg_port_arbiter

Round-robin arbiter that shares one peripheral register port (the wr_*/rd_* interface used by the peripheral controllers behind the AXI4-Lite slave interface) between two requesters. Port 0 is the CPU path from the AXI4-Lite interface unit; port 1 is a local hardware engine, for example a game-tick sequencer polling button state.

The arbiter serialises single-beat reads and writes onto the port and returns read data to the owning requester. It guarantees that neither requester waits for more than one foreign transaction.

## Interface
- ADDR_BITS, 4, register address width
- DATA_WIDTH, 32, register data width; strobe width is DATA_WIDTH/8
- RD_LATENCY, 1, cycles from the peripheral sampling rd_en to rd_data being valid; range 1–7
- s_axi_aclk  in  1  clock; all logic is on the rising edge
- s_axi_aresetn  in  1  asynchronous active-low reset
- mN_req  in  1  request from requester N (N = 0, 1); held with its fields until mN_gnt
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_BITS  register address
- mN_wdata  in  DATA_WIDTH  write data
- mN_strb  in  DATA_WIDTH/8  byte enables
- mN_gnt  out  1  one-cycle pulse when the transaction is issued
- mN_rvalid  out  1  one-cycle pulse when read data is returned
- mN_rdata  out  DATA_WIDTH  read data; valid with rvalid and held until the next read by N
- wr_addr, wr_data, wr_strb  out  ADDR_BITS / DATA_WIDTH / DATA_WIDTH/8  peripheral write fields
- wr_en  out  1  peripheral write strobe
- rd_addr  out  ADDR_BITS  peripheral read address
- rd_en  out  1  peripheral read strobe
- rd_data  in  DATA_WIDTH  peripheral read data

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_RD.
- **IDLE, no request:** stay in IDLE.
- **IDLE, one request:** select that requester.
- **IDLE, both requesting:** select the requester that is not `last`.
- **On selection:** register owner, we, addr, wdata, strb; go to ISSUE; set `last` = owner.
- **ISSUE (exactly one cycle):**
  - owner's gnt = 1.
  - Write: wr_en = 1 with wr_addr/wr_data/wr_strb; next state IDLE.
  - Read: rd_en = 1 with rd_addr; clear the latency counter; next state WAIT_RD.
  - Requests are ignored while in ISSUE.
- **WAIT_RD:**
  - Counts RD_LATENCY edges, then captures rd_data into the owner's rdata.
  - Pulses owner's rvalid for one cycle; the other rdata is unchanged.
  - Returns to IDLE in the same cycle that rvalid is high.
  - Requests are ignored until IDLE.
- **Address/data outputs:** keep their last values when the strobes are low.
- **Requester rule:** drop req, or present the next transaction, on the edge that ends its gnt cycle. Any req still high is treated as a new request.
- **Fairness:** both requesting continuously gives strict alternation. `last` resets to 1, so port 0 wins the first tie.
- **Reset mid-operation:**
  - All state is cleared asynchronously; an in-flight read returns no rvalid.
  - State becomes IDLE and `last` = 1.
- **Reset values:** every output is 0 (gnt, rvalid, wr_en, rd_en, all address/data/strb/rdata buses).

## Timing
- req sampled high in IDLE at edge E0 → gnt, and wr_en or rd_en, high in cycle E0–E1.
- Write: IDLE again at E1; next request sampled at E2.
  - Peak write throughput is 1 transaction per 2 cycles.
- Read: rd_data captured at edge E1+RD_LATENCY; rvalid high for one cycle after that edge.
  - For RD_LATENCY = 1: rvalid in cycle E2–E3, and the next sample is at E3.
- Worst-case wait for a requester: one foreign read (2+RD_LATENCY cycles) plus its own arbitration cycle.
- No combinational path from any input to any output.

## Test plan
- **Single write:** m0 write, addr 0x4, data 0x000000A5, strb 0xF → one cycle with m0_gnt = wr_en = 1 and wr_addr = 0x4, wr_data = 0xA5; m1_gnt stays 0.
- **Single read:** m1 read, addr 0x8, peripheral returns 0x0000000F at latency 1 → rd_en pulse; m1_rvalid one cycle later with m1_rdata = 0xF; m0_rvalid = 0 and m0_rdata unchanged.
- **Simultaneous first request:** m0 and m1 both write right after reset → m0 granted first, then m1 two cycles later; bus shows m0 data, then m1 data.
- **Sustained contention:** m0 and m1 both hold req for 8 transactions → grants alternate 0,1,0,1… with no requester granted twice in a row.
- **Reset during read:** assert s_axi_aresetn = 0 while in WAIT_RD (RD_LATENCY = 3) → no rvalid, all outputs 0 immediately; after release, a tie is won by m0.
- **Latency parameter:** RD_LATENCY = 3, m0 read of 0x0000BEEF → m0_rvalid appears exactly 4 cycles after the rd_en cycle begins, with m0_rdata = 0xBEEF.

Source files
------------

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one peripheral register port between two requesters.
// Serialises single-beat reads/writes and steers read data back to the owning requester.
module reg_port_arbiter #(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_BITS-1:0]    m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_strb,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_BITS-1:0]    m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_strb,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [ADDR_BITS-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_en,
  output logic [ADDR_BITS-1:0]    rd_addr,
  output logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              o_dbg_state
);

  // Handshake: a requester holds req and its fields stable until its one-cycle gnt;
  // gnt is the acceptance, and a req still high after the gnt cycle is a new request.
  // rvalid is a one-cycle pulse with no backpressure; rdata holds until the next read.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_owner;
  logic                    r_we;
  logic                    r_last;
  logic [2:0]              r_lat_cnt;
  logic [ADDR_BITS-1:0]    r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [DATA_WIDTH/8-1:0] r_wr_strb;
  logic [ADDR_BITS-1:0]    r_rd_addr;
  logic [DATA_WIDTH-1:0]   r_rdata0;
  logic [DATA_WIDTH-1:0]   r_rdata1;
  logic [1:0]              r_rvalid;

  logic                    w_any_req;
  logic                    w_sel;
  logic                    w_take;
  logic                    w_rd_done;
  logic                    w_sel_we;
  logic [ADDR_BITS-1:0]    w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [DATA_WIDTH/8-1:0] w_sel_strb;

  // On a tie the requester that did not win last time is chosen.
  assign w_any_req   = m0_req | m1_req;
  assign w_sel       = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_sel_we    = w_sel ? m1_we    : m0_we;
  assign w_sel_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_sel ? m1_wdata : m0_wdata;
  assign w_sel_strb  = w_sel ? m1_strb  : m0_strb;
  assign w_take      = (r_state == IDLE) && w_any_req;
  assign w_rd_done   = (r_state == WAIT_RD) && (r_lat_cnt == 3'(RD_LATENCY - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = ISSUE;
      ISSUE:   w_next_state = r_we ? IDLE : WAIT_RD;
      WAIT_RD: if (w_rd_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_last    <= 1'b1;
      r_lat_cnt <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
      r_rd_addr <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_rvalid <= '0;
      // Bus fields are loaded only for their own direction so idle buses hold.
      if (w_take) begin
        r_owner <= w_sel;
        r_we    <= w_sel_we;
        r_last  <= w_sel;
        if (w_sel_we) begin
          r_wr_addr <= w_sel_addr;
          r_wr_data <= w_sel_wdata;
          r_wr_strb <= w_sel_strb;
        end else begin
          r_rd_addr <= w_sel_addr;
        end
      end
      if (r_state == ISSUE) begin
        r_lat_cnt <= '0;
      end else if (r_state == WAIT_RD) begin
        r_lat_cnt <= r_lat_cnt + 3'd1;
      end
      if (w_rd_done) begin
        r_rvalid[r_owner] <= 1'b1;
        if (r_owner) r_rdata1 <= rd_data;
        else         r_rdata0 <= rd_data;
      end
    end
  end

  assign m0_gnt      = (r_state == ISSUE) && !r_owner;
  assign m1_gnt      = (r_state == ISSUE) &&  r_owner;
  assign wr_en       = (r_state == ISSUE) &&  r_we;
  assign rd_en       = (r_state == ISSUE) && !r_we;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_strb     = r_wr_strb;
  assign rd_addr     = r_rd_addr;
  assign m0_rvalid   = r_rvalid[0];
  assign m1_rvalid   = r_rvalid[1];
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: two instances (read latency 1 and 3), a peripheral model
// per instance, and a transaction-level reference model of arbitration and timing.
module tb_reg_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]    m_req   [2];
  logic [1:0]    m_we    [2];
  logic [AW-1:0] m_addr  [2][2];
  logic [DW-1:0] m_wdata [2][2];
  logic [SW-1:0] m_strb  [2][2];
  logic [1:0]    m_gnt   [2];
  logic [1:0]    m_rvalid[2];
  logic [DW-1:0] m_rdata [2][2];
  logic [AW-1:0] wr_addr [2];
  logic [DW-1:0] wr_data [2];
  logic [SW-1:0] wr_strb [2];
  logic          wr_en   [2];
  logic [AW-1:0] rd_addr [2];
  logic          rd_en   [2];
  logic [1:0]    dbg_state [2];

  logic [DW-1:0] mem [2][16];
  int            lat_of [2] = '{1, 3};

  // reference model state
  bit            m_last [2];
  logic [DW-1:0] exp_rdata [2][2];
  logic [AW-1:0] exp_wr_addr [2];
  logic [DW-1:0] exp_wr_data [2];
  logic [SW-1:0] exp_wr_strb [2];
  logic [AW-1:0] exp_rd_addr [2];
  txn_t          pend [2][$];
  int            gnt_log[$];
  int            gnt_cyc[$];
  int            rv_seen_cyc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] prd = '0;
    int            cd = 0;
    logic [AW-1:0] pa = '0;

    reg_port_arbiter #(.ADDR_BITS(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) u_dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .m0_req(m_req[g][0]), .m0_we(m_we[g][0]), .m0_addr(m_addr[g][0]),
      .m0_wdata(m_wdata[g][0]), .m0_strb(m_strb[g][0]), .m0_gnt(m_gnt[g][0]),
      .m0_rvalid(m_rvalid[g][0]), .m0_rdata(m_rdata[g][0]),
      .m1_req(m_req[g][1]), .m1_we(m_we[g][1]), .m1_addr(m_addr[g][1]),
      .m1_wdata(m_wdata[g][1]), .m1_strb(m_strb[g][1]), .m1_gnt(m_gnt[g][1]),
      .m1_rvalid(m_rvalid[g][1]), .m1_rdata(m_rdata[g][1]),
      .wr_addr(wr_addr[g]), .wr_data(wr_data[g]), .wr_strb(wr_strb[g]), .wr_en(wr_en[g]),
      .rd_addr(rd_addr[g]), .rd_en(rd_en[g]), .rd_data(prd), .o_dbg_state(dbg_state[g])
    );

    // Peripheral: data is valid only for the single cycle ending at the capture edge.
    always @(negedge clk) begin
      if (cd > 0) begin
        cd = cd - 1;
        prd = (cd == 0) ? mem[g][pa] : $urandom;
      end else begin
        prd = $urandom;
      end
      if (rd_en[g] && rst_n) begin
        cd = LAT;
        pa = rd_addr[g];
      end
      if (!rst_n) cd = 0;
    end
  end

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_last[d]      = 1'b1;
      exp_rdata[d][0] = '0;
      exp_rdata[d][1] = '0;
      exp_wr_addr[d] = '0;
      exp_wr_data[d] = '0;
      exp_wr_strb[d] = '0;
      exp_rd_addr[d] = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) m_req[d] = 2'b00;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom);
    t.wdata = $urandom;
    t.strb  = SW'($urandom);
    return t;
  endfunction

  // Cycle-level reference: a sampling point opens 2 cycles after a write grant and
  // 2+latency cycles after a read grant; read data returns 1+latency cycles after grant.
  task automatic run_model(input int d, input bit gaps, input int max_cyc);
    int e, next_s, rv_due, rv_own, own;
    logic [DW-1:0] rv_val;
    logic [1:0] req_prev, exp_g, exp_rv;
    logic exp_wr_en, exp_rd_en;
    txn_t t;
    bit done;
    e = 0; next_s = 0; rv_due = -1; rv_own = 0; rv_val = '0; done = 0;
    req_prev = m_req[d];
    rv_seen_cyc = -1;
    gnt_log.delete();
    gnt_cyc.delete();
    while (!done && e < max_cyc) begin
      @(posedge clk);
      @(negedge clk);
      e++;
      exp_g = 2'b00; own = 0; exp_wr_en = 1'b0; exp_rd_en = 1'b0;
      if (e >= next_s && req_prev != 2'b00) begin
        if (req_prev == 2'b11) own = m_last[d] ? 0 : 1;
        else                   own = req_prev[1] ? 1 : 0;
        exp_g[own] = 1'b1;
      end
      checks++;
      if (m_gnt[d] !== exp_g) begin
        failures++;
        $display("FAIL gnt dut%0d cyc%0d: got %b want %b", d, e, m_gnt[d], exp_g);
      end
      if (exp_g != 2'b00) begin
        t = pend[own][0];
        void'(pend[own].pop_front());
        exp_wr_en = t.we;
        exp_rd_en = !t.we;
        if (t.we) begin
          exp_wr_addr[d] = t.addr;
          exp_wr_data[d] = t.wdata;
          exp_wr_strb[d] = t.strb;
          next_s = e + 2;
        end else begin
          exp_rd_addr[d] = t.addr;
          rv_due = e + 1 + lat_of[d];
          rv_own = own;
          rv_val = mem[d][t.addr];
          next_s = e + 2 + lat_of[d];
        end
        m_last[d] = (own != 0);
        gnt_log.push_back(own);
        gnt_cyc.push_back(e);
      end
      checks++;
      if (wr_en[d] !== exp_wr_en || rd_en[d] !== exp_rd_en) begin
        failures++;
        $display("FAIL strobes dut%0d cyc%0d: got wr=%b rd=%b want wr=%b rd=%b",
                 d, e, wr_en[d], rd_en[d], exp_wr_en, exp_rd_en);
      end
      exp_rv = 2'b00;
      if (e == rv_due) begin
        exp_rv[rv_own] = 1'b1;
        exp_rdata[d][rv_own] = rv_val;
      end
      if (m_rvalid[d] != 2'b00 && rv_seen_cyc < 0) rv_seen_cyc = e;
      checks++;
      if (m_rvalid[d] !== exp_rv) begin
        failures++;
        $display("FAIL rvalid dut%0d cyc%0d: got %b want %b", d, e, m_rvalid[d], exp_rv);
      end
      checks++;
      if (m_rdata[d][0] !== exp_rdata[d][0] || m_rdata[d][1] !== exp_rdata[d][1]) begin
        failures++;
        $display("FAIL rdata dut%0d cyc%0d: got %h/%h want %h/%h", d, e,
                 m_rdata[d][0], m_rdata[d][1], exp_rdata[d][0], exp_rdata[d][1]);
      end
      checks++;
      if (wr_addr[d] !== exp_wr_addr[d] || wr_data[d] !== exp_wr_data[d] ||
          wr_strb[d] !== exp_wr_strb[d] || rd_addr[d] !== exp_rd_addr[d]) begin
        failures++;
        $display("FAIL bus dut%0d cyc%0d: got %h %h %h %h want %h %h %h %h", d, e,
                 wr_addr[d], wr_data[d], wr_strb[d], rd_addr[d],
                 exp_wr_addr[d], exp_wr_data[d], exp_wr_strb[d], exp_rd_addr[d]);
      end
      // driver: hold an ungranted request, otherwise present the next queued one
      for (int i = 0; i < 2; i++) begin
        if (m_req[d][i] && !exp_g[i]) begin
          m_req[d][i] = 1'b1;
        end else if (pend[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          m_req[d][i]   = 1'b1;
          m_we[d][i]    = pend[i][0].we;
          m_addr[d][i]  = pend[i][0].addr;
          m_wdata[d][i] = pend[i][0].wdata;
          m_strb[d][i]  = pend[i][0].strb;
        end else begin
          m_req[d][i]   = 1'b0;
          m_we[d][i]    = 1'($urandom);
          m_addr[d][i]  = AW'($urandom);
          m_wdata[d][i] = $urandom;
          m_strb[d][i]  = SW'($urandom);
        end
      end
      req_prev = m_req[d];
      done = (pend[0].size() == 0) && (pend[1].size() == 0) && (m_req[d] == 2'b00) &&
             (e >= next_s) && (e > rv_due);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout dut%0d: got %0d cycles without completing, want completion", d, e);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({m_gnt[d], m_rvalid[d], wr_en[d], rd_en[d], dbg_state[d]} !== 8'h00) begin
        failures++;
        $display("FAIL reset_ctrl dut%0d: got gnt=%b rv=%b wr=%b rd=%b st=%0d want all 0",
                 d, m_gnt[d], m_rvalid[d], wr_en[d], rd_en[d], dbg_state[d]);
      end
      checks++;
      if ({wr_addr[d], wr_data[d], wr_strb[d], rd_addr[d]} !== '0) begin
        failures++;
        $display("FAIL reset_bus dut%0d: got %h %h %h %h want 0", d,
                 wr_addr[d], wr_data[d], wr_strb[d], rd_addr[d]);
      end
      checks++;
      if ({m_rdata[d][0], m_rdata[d][1]} !== 64'h0) begin
        failures++;
        $display("FAIL reset_rdata dut%0d: got %h/%h want 0", d, m_rdata[d][0], m_rdata[d][1]);
      end
    end
  endtask

  task automatic test_single_write();
    txn_t t;
    t.we = 1'b1; t.addr = 4'h4; t.wdata = 32'h0000_00A5; t.strb = 4'hF;
    pend[0].push_back(t);
    run_model(0, 1'b0, 50);
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] != 0) begin
      failures++;
      $display("FAIL single_write_grants: got %0d grants, want 1 grant to m0", gnt_log.size());
    end
    checks++;
    if (wr_addr[0] !== 4'h4 || wr_data[0] !== 32'hA5 || wr_strb[0] !== 4'hF) begin
      failures++;
      $display("FAIL single_write_bus: got %h %h %h want 4 000000a5 f",
               wr_addr[0], wr_data[0], wr_strb[0]);
    end
  endtask

  task automatic test_single_read();
    txn_t t;
    mem[0][8] = 32'h0000_000F;
    t.we = 1'b0; t.addr = 4'h8; t.wdata = '0; t.strb = '0;
    pend[1].push_back(t);
    run_model(0, 1'b0, 50);
    checks++;
    if (m_rdata[0][1] !== 32'hF || m_rdata[0][0] !== exp_rdata[0][0]) begin
      failures++;
      $display("FAIL single_read_data: got m1=%h m0=%h want m1=f m0=%h",
               m_rdata[0][1], m_rdata[0][0], exp_rdata[0][0]);
    end
  endtask

  task automatic test_simultaneous();
    txn_t t0, t1;
    apply_reset();
    t0.we = 1'b1; t0.addr = 4'h1; t0.wdata = 32'h1111_1111; t0.strb = 4'hF;
    t1.we = 1'b1; t1.addr = 4'h2; t1.wdata = 32'h2222_2222; t1.strb = 4'h3;
    pend[0].push_back(t0);
    pend[1].push_back(t1);
    run_model(0, 1'b0, 50);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 1 ||
        gnt_cyc[1] - gnt_cyc[0] != 2) begin
      failures++;
      $display("FAIL simultaneous_order: got %0d grants, want m0 then m1 two cycles later",
               gnt_log.size());
    end
  endtask

  task automatic test_contention();
    bit alt_ok;
    for (int k = 0; k < 4; k++) begin
      pend[0].push_back(rand_txn());
      pend[1].push_back(rand_txn());
    end
    run_model(0, 1'b0, 200);
    alt_ok = 1'b1;
    for (int k = 1; k < gnt_log.size(); k++)
      if (gnt_log[k] == gnt_log[k-1]) alt_ok = 1'b0;
    checks++;
    if (gnt_log.size() != 8 || !alt_ok) begin
      failures++;
      $display("FAIL contention_alternation: got %0d grants alternating=%0d want 8 alternating",
               gnt_log.size(), alt_ok);
    end
  endtask

  task automatic test_latency();
    txn_t t;
    mem[1][5] = 32'h0000_BEEF;
    t.we = 1'b0; t.addr = 4'h5; t.wdata = '0; t.strb = '0;
    pend[0].push_back(t);
    run_model(1, 1'b0, 50);
    checks++;
    if (gnt_cyc.size() != 1 || rv_seen_cyc - gnt_cyc[0] != 4 || m_rdata[1][0] !== 32'hBEEF) begin
      failures++;
      $display("FAIL latency3: got rvalid offset %0d data %h want 4 and 0000beef",
               rv_seen_cyc - (gnt_cyc.size() > 0 ? gnt_cyc[0] : 0), m_rdata[1][0]);
    end
  endtask

  task automatic test_reset_mid_read();
    txn_t t0, t1;
    mem[1][9] = $urandom | 32'h1;
    @(negedge clk);
    m_req[1][0] = 1'b1; m_we[1][0] = 1'b0; m_addr[1][0] = 4'h9;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_gnt[1] !== 2'b01 || rd_en[1] !== 1'b1) begin
      failures++;
      $display("FAIL midread_issue: got gnt=%b rd_en=%b want 01 1", m_gnt[1], rd_en[1]);
    end
    m_req[1][0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    reset_model();
    #1;
    checks++;
    if ({m_gnt[1], m_rvalid[1], wr_en[1], rd_en[1], dbg_state[1]} !== 8'h00 ||
        {wr_addr[1], wr_data[1], wr_strb[1], rd_addr[1]} !== '0 ||
        {m_rdata[1][0], m_rdata[1][1]} !== 64'h0) begin
      failures++;
      $display("FAIL midread_reset_outputs: got rd_addr=%h rdata0=%h st=%0d want all 0",
               rd_addr[1], m_rdata[1][0], dbg_state[1]);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_rvalid[1] !== 2'b00) begin
        failures++;
        $display("FAIL midread_no_rvalid cyc%0d: got %b want 00", k, m_rvalid[1]);
      end
      if (k == 1) rst_n = 1'b1;
    end
    t0.we = 1'b1; t0.addr = 4'hA; t0.wdata = $urandom; t0.strb = 4'hF;
    t1.we = 1'b1; t1.addr = 4'hB; t1.wdata = $urandom; t1.strb = 4'h1;
    pend[0].push_back(t0);
    pend[1].push_back(t1);
    run_model(1, 1'b0, 50);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0) begin
      failures++;
      $display("FAIL midread_tie_after_reset: got first=%0d n=%0d want m0 first of 2",
               gnt_log.size() > 0 ? gnt_log[0] : -1, gnt_log.size());
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) mem[d][a] = $urandom;
      for (int k = 0; k < 12; k++) begin
        pend[0].push_back(rand_txn());
        pend[1].push_back(rand_txn());
      end
      run_model(d, 1'b1, 2000);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_req[d] = 2'b00;
      m_we[d]  = 2'b00;
      for (int i = 0; i < 2; i++) begin
        m_addr[d][i]  = '0;
        m_wdata[d][i] = '0;
        m_strb[d][i]  = '0;
      end
      for (int a = 0; a < 16; a++) mem[d][a] = $urandom;
    end
    reset_model();
    test_reset();
    test_single_write();
    test_single_read();
    test_simultaneous();
    test_contention();
    test_latency();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
